sysid_checker: RTL and testbench

Avalon-MM read master that sequences the 1-bit-address system ID slave after reset or on request. It reads the ID word at address 0 and the timestamp word at address 1, compares both against build-time expected values, and retries on mismatch or timeout. It exposes the captured values and pass/fail status to the boot controller and LEDs. It sits between the system ID slave's control port and the board-level status logic.

---
 rtl/sysid_checker.sv | 191 +++++++++++++++++++
 tb/tb_sysid_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Purpose : Avalon-MM read master that fetches the system ID (addr 0) and timestamp (addr 1)
//           words, compares them against build-time values and retries on mismatch/timeout.
// Latency : zero-wait slave, READ_LATENCY=0: done rises 4 cycles after start is sampled.
// Backpr. : av_address/av_read are held while av_waitrequest=1; a stall of TIMEOUT_CYCLES
//           cycles abandons the attempt. A start pulse while busy is dropped, not queued.
//
// Ports:
//   clock, reset_n        system clock (rising edge), async active-low reset
//   start                 one-cycle re-run request, ignored while busy
//   av_address, av_read   Avalon read master outputs (address 0=ID, 1=timestamp)
//   av_waitrequest        slave stall
//   av_readdata           slave read data
//   busy, done, pass      run in progress / sticky end-of-run / sticky final-attempt match
//   timeout               sticky: last attempt ended by a stall timeout
//   sys_id, sys_timestamp captured words
//   attempts              attempts used in the current run
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1521152775,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] sys_id,
  output logic [31:0] sys_timestamp,
  output logic [3:0]  attempts
);

  typedef enum logic [2:0] {
    IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, RETRY, FINISH
  } state_e;

  // Stall count at which the current cycle is the last one allowed.
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  // Latency counter value on the cycle readdata becomes valid.
  localparam logic [1:0]  LAT_LAST  = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic        auto_q, auto_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [31:0] sys_id_q, sys_id_d;
  logic [31:0] sys_ts_q, sys_ts_d;
  logic [3:0]  attempts_q, attempts_d;
  logic [15:0] tmo_q, tmo_d;
  logic [1:0]  lat_q, lat_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      auto_q     <= 1'b1;   // first run starts by itself after reset release
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      sys_id_q   <= 32'd0;
      sys_ts_q   <= 32'd0;
      attempts_q <= 4'd0;
      tmo_q      <= 16'd0;
      lat_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      sys_id_q   <= sys_id_d;
      sys_ts_q   <= sys_ts_d;
      attempts_q <= attempts_d;
      tmo_q      <= tmo_d;
      lat_q      <= lat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    auto_d     = auto_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    sys_id_d   = sys_id_q;
    sys_ts_d   = sys_ts_q;
    attempts_d = attempts_q;
    tmo_d      = 16'd0;   // stall counter only survives consecutive stalled cycles
    lat_d      = 2'd0;
    av_read    = 1'b0;
    av_address = 1'b0;

    case (state_q)
      IDLE: begin
        if (auto_q || start) begin
          state_d    = RD_ID;
          auto_d     = 1'b0;
          attempts_d = 4'd1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end

      RD_ID, RD_TS: begin
        av_read    = 1'b1;
        av_address = (state_q == RD_TS);
        if (!av_waitrequest) begin
          if (READ_LATENCY == 0) begin
            if (state_q == RD_ID) begin
              sys_id_d = av_readdata;
              state_d  = RD_TS;
            end else begin
              sys_ts_d = av_readdata;
              state_d  = CHECK;
            end
          end else begin
            state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Give up on this attempt; nothing is captured.
          timeout_d = 1'b1;
          state_d   = RETRY;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      LAT_ID, LAT_TS: begin
        av_address = (state_q == LAT_TS);
        if (lat_q == LAT_LAST) begin
          if (state_q == LAT_ID) begin
            sys_id_d = av_readdata;
            state_d  = RD_TS;
          end else begin
            sys_ts_d = av_readdata;
            state_d  = CHECK;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      CHECK: begin
        if ((sys_id_q == EXPECTED_ID) && (sys_ts_q == EXPECTED_TIMESTAMP)) begin
          pass_d    = 1'b1;
          timeout_d = 1'b0;
          state_d   = FINISH;
        end else begin
          state_d = RETRY;
        end
      end

      RETRY: begin
        if (attempts_q <= RETRY_MAX) begin
          attempts_d = attempts_q + 4'd1;
          timeout_d  = 1'b0;
          state_d    = RD_ID;
        end else begin
          pass_d  = 1'b0;
          state_d = FINISH;
        end
      end

      FINISH: begin
        // start is not looked at here, so a pulse on this cycle is dropped.
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE) && (state_q != FINISH);
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign sys_id        = sys_id_q;
  assign sys_timestamp = sys_ts_q;
  assign attempts      = attempts_q;

endmodule

// File: tb/tb_sysid_checker.sv
module tb_sysid_checker;

  localparam logic [31:0] TS_OK = 32'd1521152775;   // 32'h5AAA_F307

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- DUT 0: default parameters, zero-wait slave ----------------
  logic        reset_n0 = 1'b0;
  logic        start0   = 1'b0;
  logic        wait0    = 1'b0;
  logic [31:0] id0      = 32'd0;
  logic        av_address0, av_read0, busy0, done0, pass0, timeout0;
  logic [31:0] av_readdata0, sys_id0, sys_ts0;
  logic [3:0]  attempts0;

  assign av_readdata0 = av_address0 ? TS_OK : id0;

  sysid_checker u_dut0 (
    .clock(clock), .reset_n(reset_n0), .start(start0),
    .av_address(av_address0), .av_read(av_read0),
    .av_waitrequest(wait0), .av_readdata(av_readdata0),
    .busy(busy0), .done(done0), .pass(pass0), .timeout(timeout0),
    .sys_id(sys_id0), .sys_timestamp(sys_ts0), .attempts(attempts0)
  );

  int         rd_cnt0;
  logic [7:0] hist0;
  always @(posedge clock) begin
    if (!reset_n0) begin
      rd_cnt0 <= 0;
      hist0   <= 8'd0;
    end else if (av_read0) begin
      rd_cnt0 <= rd_cnt0 + 1;
      hist0   <= {hist0[6:0], av_address0};
    end
  end

  // ---------- DUT 1: READ_LATENCY=2, TIMEOUT_CYCLES=5, stalling slave ----------
  logic        reset_n1    = 1'b0;
  logic        start1      = 1'b0;
  logic        force_wait1 = 1'b0;
  logic        wait1;
  logic        av_address1, av_read1, busy1, done1, pass1, timeout1;
  logic [31:0] av_readdata1, sys_id1, sys_ts1;
  logic [3:0]  attempts1;
  int          stall_cnt1, rd_cnt1, run1, max_run1, viol1;
  logic        p1_vld, p1_addr, p2_vld, p2_addr, prev_stall1, prev_addr1;

  // Address 1 stalls for 3 cycles; data is valid only 2 cycles after acceptance.
  assign wait1 = force_wait1 | (av_read1 & av_address1 & (stall_cnt1 < 3));
  assign av_readdata1 = p2_vld ? (p2_addr ? TS_OK : 32'd0) : 32'hDEADBEEF;

  sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(5)) u_dut1 (
    .clock(clock), .reset_n(reset_n1), .start(start1),
    .av_address(av_address1), .av_read(av_read1),
    .av_waitrequest(wait1), .av_readdata(av_readdata1),
    .busy(busy1), .done(done1), .pass(pass1), .timeout(timeout1),
    .sys_id(sys_id1), .sys_timestamp(sys_ts1), .attempts(attempts1)
  );

  always @(posedge clock) begin
    if (!reset_n1) begin
      stall_cnt1 <= 0; rd_cnt1 <= 0; run1 <= 0; max_run1 <= 0; viol1 <= 0;
      p1_vld <= 1'b0; p1_addr <= 1'b0; p2_vld <= 1'b0; p2_addr <= 1'b0;
      prev_stall1 <= 1'b0; prev_addr1 <= 1'b0;
    end else begin
      p1_vld  <= av_read1 & ~wait1;
      p1_addr <= av_address1;
      p2_vld  <= p1_vld;
      p2_addr <= p1_addr;
      if (av_read1 && av_address1 && wait1) stall_cnt1 <= stall_cnt1 + 1;
      if (av_read1) begin
        rd_cnt1 <= rd_cnt1 + 1;
        run1    <= run1 + 1;
        if (run1 + 1 > max_run1) max_run1 <= run1 + 1;
      end else begin
        run1 <= 0;
      end
      // A stalled read must stay asserted with the same address.
      if (prev_stall1 && !(av_read1 && (av_address1 == prev_addr1))) viol1 <= viol1 + 1;
      prev_stall1 <= av_read1 & wait1;
      prev_addr1  <= av_address1;
    end
  end

  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int which, input int budget, input string tag);
    int   n;
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < budget) begin
      @(negedge clock);
      d = (which == 0) ? done0 : done1;
      n++;
    end
    chk(tag, 32'(d), 32'd1);
  endtask

  task automatic pulse_start0();
    @(negedge clock);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
  endtask

  initial begin
    int base;

    // ---- reset state ----
    #12;
    chk("rst_av_read",  32'(av_read0),  32'd0);
    chk("rst_busy",     32'(busy0),     32'd0);
    chk("rst_done",     32'(done0),     32'd0);
    chk("rst_attempts", 32'(attempts0), 32'd0);
    chk("rst_sys_id",   sys_id0,        32'd0);

    // ---- T1: auto-start after reset, zero wait, correct words ----
    @(negedge clock);
    reset_n0 = 1'b1;
    @(negedge clock);
    chk("t1_first_read", 32'(av_read0),    32'd1);
    chk("t1_first_addr", 32'(av_address0), 32'd0);
    chk("t1_busy",       32'(busy0),       32'd1);
    wait_done(0, 20, "t1_done");
    chk("t1_reads",    32'(rd_cnt0),   32'd2);
    chk("t1_addr_seq", 32'(hist0[1:0]), 32'd1);
    chk("t1_pass",     32'(pass0),     32'd1);
    chk("t1_timeout",  32'(timeout0),  32'd0);
    chk("t1_attempts", 32'(attempts0), 32'd1);
    chk("t1_sys_id",   sys_id0,        32'd0);
    chk("t1_sys_ts",   sys_ts0,        TS_OK);

    // ---- T2: wrong ID on every attempt -> 4 sequences, fail ----
    id0  = 32'h1234;
    base = rd_cnt0;
    pulse_start0();
    chk("t2_done_clr", 32'(done0),     32'd0);
    chk("t2_pass_clr", 32'(pass0),     32'd0);
    chk("t2_att_one",  32'(attempts0), 32'd1);
    wait_done(0, 100, "t2_done");
    chk("t2_reads",    32'(rd_cnt0 - base), 32'd8);
    chk("t2_pass",     32'(pass0),     32'd0);
    chk("t2_timeout",  32'(timeout0),  32'd0);
    chk("t2_attempts", 32'(attempts0), 32'd4);
    chk("t2_sys_id",   sys_id0,        32'h1234);

    // ---- T5: minimum latency; start in RD_TS and in FINISH is dropped ----
    id0  = 32'd0;
    base = rd_cnt0;
    pulse_start0();                        // accepted at e0, now in RD_ID
    chk("t5_busy_e0",  32'(busy0),  32'd1);
    chk("t5_done_clr", 32'(done0),  32'd0);
    @(negedge clock);                      // RD_TS
    chk("t5_rdts_addr", 32'(av_address0), 32'd1);
    start0 = 1'b1;
    @(negedge clock);                      // CHECK
    start0 = 1'b0;
    chk("t5_busy_e2", 32'(busy0), 32'd1);
    chk("t5_done_e2", 32'(done0), 32'd0);
    @(negedge clock);                      // FINISH
    chk("t5_busy_e3", 32'(busy0), 32'd0);
    chk("t5_done_e3", 32'(done0), 32'd0);
    chk("t5_pass_e3", 32'(pass0), 32'd1);
    start0 = 1'b1;
    @(negedge clock);                      // IDLE, done visible 4 cycles after start
    start0 = 1'b0;
    chk("t5_done_e4", 32'(done0), 32'd1);
    repeat (3) @(negedge clock);
    chk("t5_busy_after", 32'(busy0),          32'd0);
    chk("t5_reads",      32'(rd_cnt0 - base), 32'd2);
    chk("t5_attempts",   32'(attempts0),      32'd1);

    // ---- T6: async reset in the middle of a stalled read ----
    wait0 = 1'b1;
    pulse_start0();
    chk("t6_read_pre", 32'(av_read0), 32'd1);
    #2 reset_n0 = 1'b0;
    #1;
    chk("t6_read_rst",  32'(av_read0),  32'd0);
    chk("t6_busy_rst",  32'(busy0),     32'd0);
    chk("t6_done_rst",  32'(done0),     32'd0);
    chk("t6_pass_rst",  32'(pass0),     32'd0);
    chk("t6_att_rst",   32'(attempts0), 32'd0);
    chk("t6_ts_rst",    sys_ts0,        32'd0);
    @(negedge clock);
    wait0    = 1'b0;
    reset_n0 = 1'b1;
    wait_done(0, 20, "t6_done");
    chk("t6_pass",     32'(pass0),     32'd1);
    chk("t6_attempts", 32'(attempts0), 32'd1);

    // ---- T4: latency 2, 3-cycle stall on address 1 ----
    @(negedge clock);
    reset_n1 = 1'b1;
    wait_done(1, 50, "t4_done");
    chk("t4_stalls",   32'(stall_cnt1), 32'd3);
    chk("t4_stable",   32'(viol1),      32'd0);
    chk("t4_reads",    32'(rd_cnt1),    32'd5);
    chk("t4_max_run",  32'(max_run1),   32'd4);
    chk("t4_pass",     32'(pass1),      32'd1);
    chk("t4_attempts", 32'(attempts1),  32'd1);
    chk("t4_sys_id",   sys_id1,         32'd0);
    chk("t4_sys_ts",   sys_ts1,         TS_OK);

    // ---- T3: waitrequest stuck high, TIMEOUT_CYCLES=5 ----
    @(negedge clock);
    reset_n1    = 1'b0;
    force_wait1 = 1'b1;
    @(negedge clock);
    reset_n1 = 1'b1;
    wait_done(1, 200, "t3_done");
    chk("t3_reads",    32'(rd_cnt1),   32'd20);
    chk("t3_max_run",  32'(max_run1),  32'd5);
    chk("t3_timeout",  32'(timeout1),  32'd1);
    chk("t3_pass",     32'(pass1),     32'd0);
    chk("t3_attempts", 32'(attempts1), 32'd4);
    chk("t3_sys_id",   sys_id1,        32'd0);
    chk("t3_sys_ts",   sys_ts1,        32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
